// File: rtl/sssp_partition_streamer.sv
// Host-side producer for the SSSP slave input stream: per partition one meta line,
// then vertex and edge cache lines fetched through an in-order, credit-limited read port.
module sssp_partition_streamer #(
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter int unsigned ADDR_W          = 42
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [31:0]       desc_vertex_idx,
    input  logic [15:0]       desc_level,
    input  logic [31:0]       desc_vertex_ncl,
    input  logic [31:0]       desc_edge_ncl,
    input  logic [ADDR_W-1:0] desc_vertex_addr,
    input  logic [ADDR_W-1:0] desc_edge_addr,
    input  logic              desc_last,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_ready,
    input  logic              rd_rsp_valid,
    input  logic [511:0]      rd_rsp_data,
    output logic [511:0]      dout,
    output logic              dout_valid,
    output logic              dout_done,
    input  logic [511:0]      nin,
    input  logic              nin_valid,
    output logic [31:0]       update_count,
    output logic              busy,
    output logic              pass_done,
    output logic [15:0]       err_count
);

    localparam int unsigned         CREDIT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_META,
        S_FETCH,
        S_DRAIN,
        S_DONE_GAP,
        S_WAIT_NOTIFY
    } state_t;

    state_t state, state_nxt;

    logic [31:0]         d_vertex_idx;
    logic [15:0]         d_level;
    logic [31:0]         d_vertex_ncl;
    logic [31:0]         d_edge_ncl;
    logic [ADDR_W-1:0]   d_vertex_addr;
    logic [ADDR_W-1:0]   d_edge_addr;
    logic                d_last;

    logic [CREDIT_W-1:0] credits;
    logic [31:0]         vtx_left;
    logic [31:0]         edge_left;
    logic [32:0]         rsp_left;
    logic                gap_cnt;

    logic                desc_fire;
    logic                desc_bad;
    logic                req_fire;
    logic                rsp_take;
    logic                last_req;
    logic                unused_nin;

    assign desc_fire  = desc_valid && desc_ready;
    assign desc_bad   = (d_vertex_ncl == '0) || (d_edge_ncl == '0);
    assign req_fire   = rd_req_valid && rd_req_ready;
    // Responses only count while a partition is live; strays after a reset are dropped.
    assign rsp_take   = rd_rsp_valid && ((state == S_FETCH) || (state == S_DRAIN));
    assign last_req   = (vtx_left == '0) && (edge_left == 32'd1);
    assign unused_nin = ^{nin[511:96], nin[63:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (desc_fire) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (desc_bad) begin
                    state_nxt = d_last ? S_DONE_GAP : S_IDLE;
                end else begin
                    state_nxt = S_META;
                end
            end
            S_META: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (req_fire && last_req) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rsp_left == '0) begin
                    state_nxt = d_last ? S_DONE_GAP : S_IDLE;
                end
            end
            S_DONE_GAP: begin
                if (gap_cnt) begin
                    state_nxt = S_WAIT_NOTIFY;
                end
            end
            S_WAIT_NOTIFY: begin
                if (nin_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Combinational outputs, held low while reset is asserted
    always_comb begin
        desc_ready   = 1'b0;
        rd_req_valid = 1'b0;
        busy         = 1'b0;
        if (!reset) begin
            desc_ready   = (state == S_IDLE);
            rd_req_valid = (state == S_FETCH) && (credits != '0);
            busy         = (state != S_IDLE);
        end
    end

    // Descriptor latch
    always_ff @(posedge clk) begin
        if (reset) begin
            d_vertex_idx  <= '0;
            d_level       <= '0;
            d_vertex_ncl  <= '0;
            d_edge_ncl    <= '0;
            d_vertex_addr <= '0;
            d_edge_addr   <= '0;
            d_last        <= 1'b0;
        end else if (desc_fire) begin
            d_vertex_idx  <= desc_vertex_idx;
            d_level       <= desc_level;
            d_vertex_ncl  <= desc_vertex_ncl;
            d_edge_ncl    <= desc_edge_ncl;
            d_vertex_addr <= desc_vertex_addr;
            d_edge_addr   <= desc_edge_addr;
            d_last        <= desc_last;
        end
    end

    // Request address walk: vertex lines first, then edge lines
    always_ff @(posedge clk) begin
        if (reset) begin
            vtx_left    <= '0;
            edge_left   <= '0;
            rd_req_addr <= '0;
        end else if (state == S_META) begin
            vtx_left    <= d_vertex_ncl;
            edge_left   <= d_edge_ncl;
            rd_req_addr <= d_vertex_addr;
        end else if (req_fire) begin
            if (vtx_left != '0) begin
                vtx_left    <= vtx_left - 32'd1;
                rd_req_addr <= (vtx_left == 32'd1) ? d_edge_addr : rd_req_addr + ADDR_W'(1);
            end else begin
                edge_left   <= edge_left - 32'd1;
                rd_req_addr <= rd_req_addr + ADDR_W'(1);
            end
        end
    end

    // Credits: accept and response in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= CREDIT_MAX;
        end else if (req_fire && !rsp_take) begin
            credits <= credits - CREDIT_W'(1);
        end else if (rsp_take && !req_fire && (credits != CREDIT_MAX)) begin
            credits <= credits + CREDIT_W'(1);
        end
    end

    // Outstanding responses for the current partition
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_left <= '0;
        end else if (state == S_META) begin
            rsp_left <= {1'b0, d_vertex_ncl} + {1'b0, d_edge_ncl};
        end else if (rsp_take && (rsp_left != '0)) begin
            rsp_left <= rsp_left - 33'd1;
        end
    end

    // Registered stream, end-of-pass and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            dout         <= '0;
            dout_valid   <= 1'b0;
            dout_done    <= 1'b0;
            gap_cnt      <= 1'b0;
            err_count    <= '0;
            update_count <= '0;
            pass_done    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            dout_done  <= 1'b0;
            pass_done  <= 1'b0;
            if (state == S_META) begin
                dout       <= {400'b0, d_level, d_edge_ncl, d_vertex_ncl, d_vertex_idx};
                dout_valid <= 1'b1;
            end else if (rsp_take) begin
                dout       <= rd_rsp_data;
                dout_valid <= 1'b1;
            end
            gap_cnt <= (state == S_DONE_GAP);
            if ((state == S_DONE_GAP) && gap_cnt) begin
                dout_done <= 1'b1;
            end
            if ((state == S_CHECK) && desc_bad && (err_count != '1)) begin
                err_count <= err_count + 16'd1;
            end
            if ((state == S_WAIT_NOTIFY) && nin_valid) begin
                update_count <= nin[95:64];
                pass_done    <= 1'b1;
            end
        end
    end

endmodule
